pico_wb_bridge: RTL and testbench
=================================

PICO_WB_BRIDGE -- requirements
Module: pico_wb_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles from strobe acceptance to ack/err before the bridge aborts.
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned to the CPU on error or timeout.
REQ-003 i_clk  in  1  single system clock; all logic on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_mem_valid, i_mem_instr, i_mem_addr[31:0], i_mem_wdata[31:0], i_mem_wstrb[3:0]  in: CPU native request; wstrb==0 means read.
REQ-006 o_mem_ready  out  1; o_mem_rdata  out  32: CPU completion.
REQ-007 o_wb_addr[31:0], o_wb_data[31:0], o_wb_sel[3:0], o_wb_we, o_wb_cyc, o_wb_stb  out: Wishbone pipelined master.
REQ-008 i_wb_ack, i_wb_stall, i_wb_err  in  1 each; i_wb_data  in  32: Wishbone slave response.
REQ-009 o_bus_err  out  1 sticky error flag; o_bus_err_addr  out  32 address of the first failing access.

Function
REQ-010 FSM states: IDLE, REQ, WAIT, DONE.
REQ-011 IDLE: when i_mem_valid=1 and o_mem_ready=0, register addr/wdata/wstrb, then go to REQ with cyc=stb=1 on the next cycle.
REQ-012 Drive o_wb_we = |wstrb; o_wb_sel = wstrb for writes, 4'hF for reads; o_wb_addr = i_mem_addr unchanged.
REQ-013 REQ: hold stb and all request fields stable while i_wb_stall=1; once stall=0, drop stb on the next cycle and go to WAIT.
REQ-014 WAIT: hold cyc=1 until i_wb_ack or i_wb_err; on either, drop cyc the next cycle and go to DONE.
REQ-015 Accept an ack or err arriving in REQ in the same cycle stall=0; this path goes directly to DONE.
REQ-016 DONE: pulse o_mem_ready for exactly one cycle, then return to IDLE.
REQ-017 Read data: on ack, o_mem_rdata = i_wb_data captured on the ack cycle; on err, o_mem_rdata = ERR_RDATA; writes return 0.
REQ-018 Allow one transaction in flight only; no new request is taken until the cycle after o_mem_ready.
REQ-019 Minimum latency with a zero-wait slave and registered ack (ack 1 cycle after stb): valid -> ready in 4 cycles.
REQ-020 On error, set o_bus_err; load o_bus_err_addr only when o_bus_err was 0 (first error kept).
REQ-021 Clear o_bus_err only on reset.
REQ-022 Ignore a spurious ack/err while in IDLE; it has no effect.
REQ-023 Ignore i_mem_instr functionally; it is captured for debug only.

Reset
REQ-024 While i_reset=1, asynchronously force: state=IDLE; cyc=stb=we=0; sel=0; addr=data=0; o_mem_ready=0; o_mem_rdata=0; o_bus_err=0; o_bus_err_addr=0.
REQ-025 If reset hits mid-transaction, abandon the transaction; no ready pulse follows reset release.

Configuration
REQ-026 Macro PICO_WB_TIMEOUT_EN: when defined, a counter starts when the bridge enters REQ and clears in IDLE.
REQ-027 When the counter reaches TIMEOUT_CYCLES, treat the transaction as an error per REQ-017/020: drop cyc/stb, go to DONE.
REQ-028 Without PICO_WB_TIMEOUT_EN, no counter exists and the bridge waits indefinitely.

Structure
REQ-029 Put the shared package wb_pkg in charge of: FSM state encoding, the WB slave address constants (SRAM 0x0000_0000, LED 0x8000_0000, UART 0x8000_0008, CDT 0x8000_0010), and the default ERR_RDATA.
REQ-030 Implement the timeout as sub-module wb_timeout (enable, clear, expire), instantiated only under PICO_WB_TIMEOUT_EN.

Verification
REQ-031 Write addr 0x8000_0000, wdata 0x3F, wstrb 4'hF, ack 1 cycle after stb -> we=1, sel=F, cyc for 2 cycles, ready at cycle 4, rdata=0.
REQ-032 Read 0x8000_0000, slave returns 0x0000_002A with ack -> o_mem_rdata=0x2A on the single ready cycle.
REQ-033 Stall held 3 cycles -> stb stays high with addr/data stable for 4 cycles, ready at cycle 7.
REQ-034 Err on 0x9000_0000 read, then a second err on 0x9000_0004 -> rdata=0xDEAD_BEEF, o_bus_err=1, o_bus_err_addr stays 0x9000_0000.
REQ-035 With PICO_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 cycles, ready pulses, o_bus_err=1.
REQ-036 Assert i_reset in WAIT -> outputs go to reset values immediately; after release, a late ack produces no ready.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the PicoRV32-to-Wishbone bridge: FSM state
// encoding, the Wishbone slave address map and the default error read data.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

  // Slave address map
  localparam logic [31:0] WB_ADDR_SRAM = 32'h0000_0000;
  localparam logic [31:0] WB_ADDR_LED  = 32'h8000_0000;
  localparam logic [31:0] WB_ADDR_UART = 32'h8000_0008;
  localparam logic [31:0] WB_ADDR_CDT  = 32'h8000_0010;

  // Read data handed to the CPU when an access fails or times out
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  // Byte lanes for a native request: a zero strobe is a full-word read.
  function automatic logic [3:0] wb_sel_for(input logic [3:0] wstrb);
    return (wstrb == 4'h0) ? 4'hF : wstrb;
  endfunction

endpackage

// File: rtl/pico_wb_bridge_if.sv
// Bus bundles for the bridge: the PicoRV32 native memory port and the
// Wishbone pipelined master port, each with master/slave views.
interface pico_mem_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

interface wb_if;
  logic [31:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_ack;
  logic        wb_stall;
  logic        wb_err;
  logic [31:0] wb_rdata;

  modport master (output wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb,
                  input  wb_ack, wb_stall, wb_err, wb_rdata);
  modport slave  (input  wb_addr, wb_wdata, wb_sel, wb_we, wb_cyc, wb_stb,
                  output wb_ack, wb_stall, wb_err, wb_rdata);
endinterface

// File: rtl/wb_timeout.sv
// Transaction watchdog: counts cycles while enabled and flags expiry on the
// TIMEOUT_CYCLES-th enabled cycle; clear returns the count to zero.
module wb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expire
);

  localparam int unsigned       CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign o_expire = i_enable && (count_q == LAST);

  // Count enabled cycles, saturating once expiry has been flagged.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && !o_expire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pico_wb_bridge.sv
// PicoRV32 native memory port to Wishbone pipelined master bridge with one
// transaction in flight and a sticky bus-error flag.
// Optional watchdog: define PICO_WB_TIMEOUT_EN to abort accesses that see no
// ack/err within TIMEOUT_CYCLES; without it the bridge waits indefinitely.
module pico_wb_bridge
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  pico_mem_if.slave   mem,
  wb_if.master        wb,
  output logic        o_bus_err,
  output logic [31:0] o_bus_err_addr,
  output logic        o_dbg_instr
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("pico_wb_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  bridge_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   err_addr_q, err_addr_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          instr_q, instr_d;
  logic          bus_err_q, bus_err_d;

  logic in_flight;
  logic resp_take;
  logic finish;
  logic finish_err;
  logic timeout_expire;

  assign in_flight = (state_q == REQ) || (state_q == WAIT);

`ifdef PICO_WB_TIMEOUT_EN
  wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (in_flight),
    .i_clear  (state_q == IDLE),
    .o_expire (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // A response only counts once stb is accepted: REQ with stall low, or WAIT.
  assign resp_take  = (wb.wb_ack || wb.wb_err) &&
                      (((state_q == REQ) && !wb.wb_stall) || (state_q == WAIT));
  assign finish     = resp_take || (in_flight && timeout_expire);
  // A real response beats a simultaneous expiry; expiry alone is an error.
  assign finish_err = resp_take ? wb.wb_err : 1'b1;

  // Next state, request capture and completion bookkeeping.
  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    sel_d      = sel_q;
    we_d       = we_q;
    instr_d    = instr_q;
    bus_err_d  = bus_err_q;

    case (state_q)
      IDLE: begin
        if (mem.mem_valid && !mem.mem_ready) begin
          addr_d  = mem.mem_addr;
          wdata_d = mem.mem_wdata;
          sel_d   = wb_sel_for(mem.mem_wstrb);
          we_d    = |mem.mem_wstrb;
          instr_d = mem.mem_instr;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!wb.wb_stall) state_d = WAIT;
      end
      WAIT: ; // leaves only through the completion path below
      DONE: begin
        rdata_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = DONE;
      if (we_q)            rdata_d = '0;
      else if (finish_err) rdata_d = ERR_RDATA;
      else                 rdata_d = wb.wb_rdata;
      if (finish_err) begin
        bus_err_d = 1'b1;
        if (!bus_err_q) err_addr_d = addr_q;
      end
    end
  end

  // Bridge registers; reset abandons any transaction in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      instr_q    <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the values from before the edge.
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      instr_q    <= instr_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign wb.wb_cyc        = in_flight;
  assign wb.wb_stb        = (state_q == REQ);
  assign wb.wb_addr       = addr_q;
  assign wb.wb_wdata      = wdata_q;
  assign wb.wb_sel        = sel_q;
  assign wb.wb_we         = we_q;
  assign mem.mem_ready    = (state_q == DONE);
  assign mem.mem_rdata    = rdata_q;
  assign o_bus_err        = bus_err_q;
  assign o_bus_err_addr   = err_addr_q;
  assign o_dbg_instr      = instr_q;

endmodule

// File: tb/tb_pico_wb_bridge.sv
// Directed bench for pico_wb_bridge: each task drives one scenario and
// compares DUT outputs against hand-computed values.
module tb_pico_wb_bridge;
  import wb_pkg::*;

  localparam int XFER_BUDGET = 64;
`ifdef PICO_WB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  typedef struct {
    int          latency;
    logic [31:0] rdata;
    int          cyc_n;
    int          stb_n;
    bit          stable;
    int          ready_n;
  } xfer_res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_err;
  logic [31:0] bus_err_addr;
  logic        dbg_instr;
  int          n_checks = 0;
  int          n_fail   = 0;

  pico_mem_if mem_bus ();
  wb_if       wb_bus ();

  pico_wb_bridge #(
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .mem            (mem_bus),
    .wb             (wb_bus),
    .o_bus_err      (bus_err),
    .o_bus_err_addr (bus_err_addr),
    .o_dbg_instr    (dbg_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, fails so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slave();
    wb_bus.wb_ack   = 1'b0;
    wb_bus.wb_err   = 1'b0;
    wb_bus.wb_stall = 1'b0;
    wb_bus.wb_rdata = 32'hA5A5_A5A5;
  endtask

  // CPU + slave driver for one access. Cycle 1 is the cycle valid rises.
  // resp_delay: 0 = respond with the accepted stb, n = n cycles later, <0 = never.
  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr,
                          input int stall_n, input int resp_delay, input bit give_err,
                          input logic [31:0] resp_data, output xfer_res_t r);
    logic [3:0] sel_exp;
    logic       we_exp;
    int         stall_left;
    int         wait_left;
    bit         pending;
    sel_exp    = (wstrb == 4'h0) ? 4'hF : wstrb;
    we_exp     = (wstrb != 4'h0);
    r.latency  = -1;
    r.rdata    = '0;
    r.cyc_n    = 0;
    r.stb_n    = 0;
    r.stable   = 1'b1;
    r.ready_n  = 0;
    stall_left = stall_n;
    wait_left  = 0;
    pending    = 1'b0;
    mem_bus.mem_valid = 1'b1;
    mem_bus.mem_instr = instr;
    mem_bus.mem_addr  = addr;
    mem_bus.mem_wdata = wdata;
    mem_bus.mem_wstrb = wstrb;
    for (int c = 1; c <= XFER_BUDGET; c++) begin
      if (wb_bus.wb_cyc) r.cyc_n++;
      if (wb_bus.wb_stb) begin
        r.stb_n++;
        if (wb_bus.wb_addr !== addr || wb_bus.wb_wdata !== wdata ||
            wb_bus.wb_sel !== sel_exp || wb_bus.wb_we !== we_exp) r.stable = 1'b0;
      end
      if (mem_bus.mem_ready) begin
        r.ready_n++;
        r.latency = c;
        r.rdata   = mem_bus.mem_rdata;
        mem_bus.mem_valid = 1'b0;
        clear_slave();
        step();
        if (mem_bus.mem_ready) r.ready_n++;
        break;
      end
      clear_slave();
      if (wb_bus.wb_stb) begin
        if (stall_left > 0) begin
          wb_bus.wb_stall = 1'b1;
          stall_left--;
        end else if (resp_delay == 0) begin
          wb_bus.wb_ack   = !give_err;
          wb_bus.wb_err   = give_err;
          wb_bus.wb_rdata = resp_data;
        end else if (resp_delay > 0) begin
          pending   = 1'b1;
          wait_left = resp_delay - 1;
        end
      end else if (pending) begin
        if (wait_left == 0) begin
          wb_bus.wb_ack   = !give_err;
          wb_bus.wb_err   = give_err;
          wb_bus.wb_rdata = resp_data;
          pending = 1'b0;
        end else begin
          wait_left--;
        end
      end
      step();
    end
    mem_bus.mem_valid = 1'b0;
    clear_slave();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_instr = 1'b0;
    mem_bus.mem_addr  = '0;
    mem_bus.mem_wdata = '0;
    mem_bus.mem_wstrb = '0;
    clear_slave();
    step();
    step();
    n_checks++; if (wb_bus.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_cyc: got %b want 0", wb_bus.wb_cyc); end
    n_checks++; if (wb_bus.wb_stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", wb_bus.wb_stb); end
    n_checks++; if (mem_bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", mem_bus.mem_ready); end
    n_checks++; if (mem_bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", mem_bus.mem_rdata); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    n_checks++; if (bus_err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_err_addr: got %h want 0", bus_err_addr); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    xfer_res_t r;
    run_xfer(WB_ADDR_LED, 32'h0, 4'h0, 1'b1, 0, 1, 1'b0, 32'h0000_002A, r);
    n_checks++; if (r.latency !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d want 4", r.latency); end
    n_checks++; if (r.rdata !== 32'h0000_002A) begin n_fail++; $display("FAIL rd_data: got %h want 0000002a", r.rdata); end
    n_checks++; if (r.ready_n !== 1) begin n_fail++; $display("FAIL rd_ready_pulse: got %0d want 1", r.ready_n); end
    n_checks++; if (r.cyc_n !== 2) begin n_fail++; $display("FAIL rd_cyc_cycles: got %0d want 2", r.cyc_n); end
    n_checks++; if (r.stable !== 1'b1) begin n_fail++; $display("FAIL rd_fields (sel=F we=0): got %b want 1", r.stable); end
    n_checks++; if (dbg_instr !== 1'b1) begin n_fail++; $display("FAIL rd_dbg_instr: got %b want 1", dbg_instr); end
  endtask

  task automatic test_write();
    xfer_res_t r;
    run_xfer(WB_ADDR_LED, 32'h0000_003F, 4'hF, 1'b0, 0, 1, 1'b0, 32'h1234_5678, r);
    n_checks++; if (r.latency !== 4) begin n_fail++; $display("FAIL wr_latency: got %0d want 4", r.latency); end
    n_checks++; if (r.cyc_n !== 2) begin n_fail++; $display("FAIL wr_cyc_cycles: got %0d want 2", r.cyc_n); end
    n_checks++; if (r.stb_n !== 1) begin n_fail++; $display("FAIL wr_stb_cycles: got %0d want 1", r.stb_n); end
    n_checks++; if (r.stable !== 1'b1) begin n_fail++; $display("FAIL wr_fields (we=1 sel=F): got %b want 1", r.stable); end
    n_checks++; if (r.rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", r.rdata); end
    n_checks++; if (r.ready_n !== 1) begin n_fail++; $display("FAIL wr_ready_pulse: got %0d want 1", r.ready_n); end
  endtask

  task automatic test_same_cycle_ack();
    xfer_res_t r;
    run_xfer(WB_ADDR_UART, 32'h0, 4'h0, 1'b0, 0, 0, 1'b0, 32'h0000_0055, r);
    n_checks++; if (r.latency !== 3) begin n_fail++; $display("FAIL fast_latency: got %0d want 3", r.latency); end
    n_checks++; if (r.cyc_n !== 1) begin n_fail++; $display("FAIL fast_cyc_cycles: got %0d want 1", r.cyc_n); end
    n_checks++; if (r.rdata !== 32'h0000_0055) begin n_fail++; $display("FAIL fast_rdata: got %h want 00000055", r.rdata); end
  endtask

  task automatic test_stall();
    xfer_res_t r;
    run_xfer(WB_ADDR_CDT, 32'h0000_0041, 4'h3, 1'b0, 3, 1, 1'b0, 32'h0, r);
    n_checks++; if (r.latency !== 7) begin n_fail++; $display("FAIL stall_latency: got %0d want 7", r.latency); end
    n_checks++; if (r.stb_n !== 4) begin n_fail++; $display("FAIL stall_stb_cycles: got %0d want 4", r.stb_n); end
    n_checks++; if (r.cyc_n !== 5) begin n_fail++; $display("FAIL stall_cyc_cycles: got %0d want 5", r.cyc_n); end
    n_checks++; if (r.stable !== 1'b1) begin n_fail++; $display("FAIL stall_fields_stable (sel=3): got %b want 1", r.stable); end
  endtask

  task automatic test_back_to_back();
    xfer_res_t r1, r2;
    run_xfer(WB_ADDR_SRAM + 32'h4, 32'h00AB_0000, 4'h4, 1'b0, 0, 1, 1'b0, 32'h0, r1);
    run_xfer(WB_ADDR_SRAM + 32'h4, 32'h0, 4'h0, 1'b1, 0, 1, 1'b0, 32'hCAFE_F00D, r2);
    n_checks++; if (r1.latency !== 4) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 4", r1.latency); end
    n_checks++; if (r1.stable !== 1'b1) begin n_fail++; $display("FAIL b2b_first_fields (sel=4): got %b want 1", r1.stable); end
    n_checks++; if (r2.latency !== 4) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 4", r2.latency); end
    n_checks++; if (r2.rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_second_rdata: got %h want cafef00d", r2.rdata); end
  endtask

  task automatic test_spurious_idle();
    wb_bus.wb_ack = 1'b1;
    wb_bus.wb_err = 1'b1;
    step();
    clear_slave();
    n_checks++; if (mem_bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL spurious_ready: got %b want 0", mem_bus.mem_ready); end
    n_checks++; if (wb_bus.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL spurious_cyc: got %b want 0", wb_bus.wb_cyc); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL spurious_bus_err: got %b want 0", bus_err); end
    step();
    n_checks++; if (mem_bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL spurious_ready_later: got %b want 0", mem_bus.mem_ready); end
  endtask

  task automatic test_errors();
    xfer_res_t r;
    run_xfer(32'h9000_0000, 32'h0, 4'h0, 1'b0, 0, 1, 1'b1, 32'h0, r);
    n_checks++; if (r.latency !== 4) begin n_fail++; $display("FAIL err1_latency: got %0d want 4", r.latency); end
    n_checks++; if (r.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err1_rdata: got %h want deadbeef", r.rdata); end
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err1_bus_err: got %b want 1", bus_err); end
    n_checks++; if (bus_err_addr !== 32'h9000_0000) begin n_fail++; $display("FAIL err1_addr: got %h want 90000000", bus_err_addr); end
    run_xfer(32'h9000_0004, 32'h0, 4'h0, 1'b0, 0, 1, 1'b1, 32'h0, r);
    n_checks++; if (r.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err2_rdata: got %h want deadbeef", r.rdata); end
    n_checks++; if (bus_err_addr !== 32'h9000_0000) begin n_fail++; $display("FAIL err2_first_addr_kept: got %h want 90000000", bus_err_addr); end
    run_xfer(WB_ADDR_SRAM, 32'h0, 4'h0, 1'b0, 0, 1, 1'b0, 32'h0000_0011, r);
    n_checks++; if (r.rdata !== 32'h0000_0011) begin n_fail++; $display("FAIL err_recover_rdata: got %h want 00000011", r.rdata); end
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", bus_err); end
  endtask

  task automatic test_reset_mid_wait();
    int ready_seen;
    int cyc_seen;
    mem_bus.mem_valid = 1'b1;
    mem_bus.mem_instr = 1'b0;
    mem_bus.mem_addr  = WB_ADDR_SRAM + 32'h10;
    mem_bus.mem_wdata = 32'h0;
    mem_bus.mem_wstrb = 4'h0;
    step();  // REQ
    step();  // WAIT, slave silent
    n_checks++; if (wb_bus.wb_cyc !== 1'b1 || wb_bus.wb_stb !== 1'b0) begin n_fail++; $display("FAIL rst_pre_wait: cyc=%b stb=%b want cyc=1 stb=0", wb_bus.wb_cyc, wb_bus.wb_stb); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (wb_bus.wb_cyc !== 1'b0) begin n_fail++; $display("FAIL rst_async_cyc: got %b want 0", wb_bus.wb_cyc); end
    n_checks++; if (wb_bus.wb_addr !== 32'h0 || wb_bus.wb_sel !== 4'h0 || wb_bus.wb_we !== 1'b0) begin n_fail++; $display("FAIL rst_async_req: addr=%h sel=%h we=%b want 0", wb_bus.wb_addr, wb_bus.wb_sel, wb_bus.wb_we); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_bus_err: got %b want 0", bus_err); end
    n_checks++; if (bus_err_addr !== 32'h0) begin n_fail++; $display("FAIL rst_async_err_addr: got %h want 0", bus_err_addr); end
    mem_bus.mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    wb_bus.wb_ack   = 1'b1;
    wb_bus.wb_rdata = 32'h7777_7777;
    ready_seen = 0;
    cyc_seen   = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      clear_slave();
      if (mem_bus.mem_ready) ready_seen++;
      if (wb_bus.wb_cyc) cyc_seen++;
    end
    n_checks++; if (ready_seen !== 0) begin n_fail++; $display("FAIL rst_late_ack_ready: got %0d pulses want 0", ready_seen); end
    n_checks++; if (cyc_seen !== 0) begin n_fail++; $display("FAIL rst_late_ack_cyc: got %0d cycles want 0", cyc_seen); end
  endtask

`ifdef PICO_WB_TIMEOUT_EN
  task automatic test_timeout();
    xfer_res_t r;
    run_xfer(32'hA000_0000, 32'h0, 4'h0, 1'b0, 0, -1, 1'b0, 32'h0, r);
    n_checks++; if (r.cyc_n !== 8) begin n_fail++; $display("FAIL to_cyc_cycles: got %0d want 8", r.cyc_n); end
    n_checks++; if (r.latency !== 10) begin n_fail++; $display("FAIL to_latency: got %0d want 10", r.latency); end
    n_checks++; if (r.ready_n !== 1) begin n_fail++; $display("FAIL to_ready_pulse: got %0d want 1", r.ready_n); end
    n_checks++; if (r.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_rdata: got %h want deadbeef", r.rdata); end
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_bus_err: got %b want 1", bus_err); end
    n_checks++; if (bus_err_addr !== 32'hA000_0000) begin n_fail++; $display("FAIL to_err_addr: got %h want a0000000", bus_err_addr); end
  endtask
`else
  task automatic test_long_wait();
    xfer_res_t r;
    run_xfer(WB_ADDR_SRAM + 32'h8, 32'h0, 4'h0, 1'b0, 0, 20, 1'b0, 32'h0BAD_F00D, r);
    n_checks++; if (r.latency !== 23) begin n_fail++; $display("FAIL slow_latency: got %0d want 23", r.latency); end
    n_checks++; if (r.cyc_n !== 21) begin n_fail++; $display("FAIL slow_cyc_cycles: got %0d want 21", r.cyc_n); end
    n_checks++; if (r.rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL slow_rdata: got %h want 0badf00d", r.rdata); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL slow_bus_err: got %b want 0", bus_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_same_cycle_ack();
    test_stall();
    test_back_to_back();
    test_spurious_idle();
    test_errors();
    test_reset_mid_wait();
`ifdef PICO_WB_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
